laser_cover_eval: RTL and testbench
===================================

LASER_COVER_EVAL -- requirements
Module: laser_cover_eval

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port PT_VALID, input, 1 bit: the X/Y point on this cycle is valid.
REQ-004 SHALL have ports X, Y, input, 4 bits each: point coordinates, unsigned 0..15.
REQ-005 SHALL have port DONE_IN, input, 1 bit: one-cycle pulse from the circle-search stage marking C1X..C2Y valid.
REQ-006 SHALL have ports C1X, C1Y, C2X, C2Y, input, 4 bits each: circle-1 and circle-2 centres, sampled when DONE_IN=1.
REQ-007 SHALL have ports CNT1, CNT2, BOTH, TOTAL, output, 6 bits each: points covered by circle 1, by circle 2, by both, and by either.
REQ-008 SHALL have port EVAL_VALID, output, 1 bit: one-cycle pulse when the count outputs are updated.
REQ-009 SHALL have port BUSY, output, 1 bit: high in states EVAL and REPORT.
REQ-010 SHALL have port ERR, output, 1 bit: sticky flag for a protocol violation in the current frame.

Function
REQ-011 SHALL implement the FSM states COLLECT, EVAL and REPORT; reset state COLLECT.
REQ-012 In COLLECT, each PT_VALID=1 cycle SHALL store (X,Y) at buffer[PCNT] and increment PCNT (6 bits), up to 40 entries.
REQ-013 PT_VALID in COLLECT with PCNT=40 SHALL drop the point and set ERR.
REQ-014 DONE_IN=1 in COLLECT SHALL latch the four centres and move to EVAL next cycle.
REQ-015 DONE_IN with PCNT not equal to 40 SHALL set ERR, and evaluation SHALL proceed over PCNT entries.
REQ-016 DONE_IN with PCNT=0 SHALL go directly to REPORT with all counts 0 and ERR=1.
REQ-017 EVAL SHALL process one buffer entry per cycle, index 0..PCNT-1, then go to REPORT.
REQ-018 Per entry: dx=|x-cx| and dy=|y-cy| (4 bits), d=dx*dx+dy*dy (9 bits unsigned, max 450); the point is covered iff d <= 16 (boundary inclusive).
REQ-019 Per entry, SHALL accumulate internal counters a1+=in1, a2+=in2, ab+=in1&in2, at+=in1|in2.
REQ-020 REPORT SHALL last 1 cycle: copy the accumulators to CNT1/CNT2/BOTH/TOTAL, pulse EVAL_VALID, clear PCNT and the accumulators, and return to COLLECT.
REQ-021 Timing: if DONE_IN is sampled at edge t with N>0 points, EVAL_VALID SHALL be high in the cycle after edge t+N+1.
REQ-022 Count outputs SHALL hold their values until the next REPORT.
REQ-023 PT_VALID or DONE_IN while BUSY=1 SHALL be ignored and SHALL set ERR; no buffer write and no centre relatch.
REQ-024 PT_VALID and DONE_IN in the same COLLECT cycle: the point SHALL be stored first (if PCNT<40), and that point SHALL be included in the evaluation.
REQ-025 ERR SHALL stay set through the REPORT of the frame and SHALL clear on the first COLLECT cycle after REPORT.
REQ-026 No combinational path SHALL exist from any input to any output; all outputs SHALL be registered.

Reset
REQ-027 RST=0 SHALL, asynchronously: set the state to COLLECT; clear PCNT and the accumulators; drive CNT1, CNT2, BOTH, TOTAL to 0; drive EVAL_VALID, BUSY and ERR to 0.
REQ-028 Reset during EVAL or REPORT SHALL abort the frame with no EVAL_VALID pulse; buffer contents need not be cleared.
REQ-029 After RST deasserts, the first PT_VALID SHALL write buffer[0].

Verification
REQ-030 Coverage scenario: 40 points at (5,5), DONE_IN with C1=(5,5), C2=(12,12) -> CNT1=40, CNT2=0, BOTH=0, TOTAL=40, ERR=0, EVAL_VALID 41 cycles after DONE_IN.
REQ-031 Boundary scenario: 20 points (9,5) and 20 points (9,6), C1=(5,5), C2=(15,15) -> CNT1=20 (d=16 in, d=17 out), CNT2=0, TOTAL=20.
REQ-032 Overlap scenario: 40 points (8,8), C1=(6,6), C2=(10,10) -> CNT1=40, CNT2=40, BOTH=40, TOTAL=40.
REQ-033 Short and overflow frames: DONE_IN after 39 points -> ERR=1, EVAL lasts 39 cycles; a 41st PT_VALID -> dropped, ERR=1.
REQ-034 Protocol scenarios: PT_VALID pulsed during EVAL -> ERR=1 and counts unaffected; RST=0 mid-EVAL -> outputs 0 immediately and no EVAL_VALID.
REQ-035 Back-to-back scenario: two consecutive 40-point frames -> second frame starts at buffer[0]; second counts are independent of the first.

Source files
------------

// File: rtl/laser_cover_eval.sv
// laser_cover_eval: buffers up to 40 points, then counts how many fall inside two
// radius-4 circles (one entry per cycle) and reports the four coverage counts.
module laser_cover_eval (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PT_VALID,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic       DONE_IN,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    output logic [5:0] CNT1,
    output logic [5:0] CNT2,
    output logic [5:0] BOTH,
    output logic [5:0] TOTAL,
    output logic       EVAL_VALID,
    output logic       BUSY,
    output logic       ERR
);
    typedef enum logic [1:0] {COLLECT, EVAL, REPORT} state_t;

    state_t     state_q, state_d;
    logic [5:0] pcnt_q, pcnt_d, idx_q, idx_d;
    logic [3:0] c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;
    logic [5:0] a1_q, a1_d, a2_q, a2_d, ab_q, ab_d, at_q, at_d;
    logic [5:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d, both_q, both_d, total_q, total_d;
    logic       ev_q, ev_d, busy_q, busy_d, err_q, err_d;
    logic       wr_en, in1, in2;
    logic [7:0] entry;
    logic [7:0] pts_q [40];

    function automatic logic covered(input logic [3:0] px, py, cx, cy);
        logic [3:0] dx, dy;
        logic [8:0] d;
        dx = px >= cx ? px - cx : cx - px;
        dy = py >= cy ? py - cy : cy - py;
        d  = {5'd0, dx} * {5'd0, dx} + {5'd0, dy} * {5'd0, dy};
        return d <= 9'd16;
    endfunction

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        idx_d   = idx_q;
        c1x_d   = c1x_q;
        c1y_d   = c1y_q;
        c2x_d   = c2x_q;
        c2y_d   = c2y_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        ab_d    = ab_q;
        at_d    = at_q;
        cnt1_d  = cnt1_q;
        cnt2_d  = cnt2_q;
        both_d  = both_q;
        total_d = total_q;
        ev_d    = 1'b0;
        err_d   = err_q;
        wr_en   = 1'b0;
        entry   = 8'd0;
        in1     = 1'b0;
        in2     = 1'b0;
        case (state_q)
            COLLECT: begin
                // ERR of the previous frame stays visible alongside its EVAL_VALID pulse
                err_d = ev_q ? 1'b0 : err_q;
                if (PT_VALID) begin
                    if (pcnt_q < 6'd40) begin
                        wr_en  = 1'b1;
                        pcnt_d = pcnt_q + 6'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (DONE_IN) begin
                    c1x_d   = C1X;
                    c1y_d   = C1Y;
                    c2x_d   = C2X;
                    c2y_d   = C2Y;
                    idx_d   = 6'd0;
                    err_d   = err_d | (pcnt_d != 6'd40);
                    state_d = pcnt_d == 6'd0 ? REPORT : EVAL;
                end
            end
            EVAL: begin
                err_d   = err_q | PT_VALID | DONE_IN;
                entry   = pts_q[idx_q];
                in1     = covered(entry[7:4], entry[3:0], c1x_q, c1y_q);
                in2     = covered(entry[7:4], entry[3:0], c2x_q, c2y_q);
                a1_d    = a1_q + {5'd0, in1};
                a2_d    = a2_q + {5'd0, in2};
                ab_d    = ab_q + {5'd0, in1 & in2};
                at_d    = at_q + {5'd0, in1 | in2};
                idx_d   = idx_q + 6'd1;
                state_d = idx_q == pcnt_q - 6'd1 ? REPORT : EVAL;
            end
            REPORT: begin
                err_d   = err_q | PT_VALID | DONE_IN;
                cnt1_d  = a1_q;
                cnt2_d  = a2_q;
                both_d  = ab_q;
                total_d = at_q;
                ev_d    = 1'b1;
                pcnt_d  = 6'd0;
                a1_d    = 6'd0;
                a2_d    = 6'd0;
                ab_d    = 6'd0;
                at_d    = 6'd0;
                state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
        busy_d = state_d != COLLECT;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= COLLECT;
            pcnt_q  <= '0;
            idx_q   <= '0;
            c1x_q   <= '0;
            c1y_q   <= '0;
            c2x_q   <= '0;
            c2y_q   <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            ab_q    <= '0;
            at_q    <= '0;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            both_q  <= '0;
            total_q <= '0;
            ev_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            idx_q   <= idx_d;
            c1x_q   <= c1x_d;
            c1y_q   <= c1y_d;
            c2x_q   <= c2x_d;
            c2y_q   <= c2y_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            ab_q    <= ab_d;
            at_q    <= at_d;
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
            both_q  <= both_d;
            total_q <= total_d;
            ev_q    <= ev_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) pts_q[pcnt_q] <= {X, Y};
    end

    assign CNT1       = cnt1_q;
    assign CNT2       = cnt2_q;
    assign BOTH       = both_q;
    assign TOTAL      = total_q;
    assign EVAL_VALID = ev_q;
    assign BUSY       = busy_q;
    assign ERR        = err_q;
endmodule

// File: tb/tb_laser_cover_eval.sv
// tb_laser_cover_eval: directed frames with hand-computed coverage counts, latency and ERR.
module tb_laser_cover_eval;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       PT_VALID = 1'b0;
    logic [3:0] X = '0, Y = '0;
    logic       DONE_IN = 1'b0;
    logic [3:0] C1X = '0, C1Y = '0, C2X = '0, C2Y = '0;
    logic [5:0] CNT1, CNT2, BOTH, TOTAL;
    logic       EVAL_VALID, BUSY, ERR;
    int         checks = 0;
    int         failures = 0;
    int         evs;

    laser_cover_eval dut (
        .CLK(CLK), .RST(RST), .PT_VALID(PT_VALID), .X(X), .Y(Y), .DONE_IN(DONE_IN),
        .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
        .CNT1(CNT1), .CNT2(CNT2), .BOTH(BOTH), .TOTAL(TOTAL),
        .EVAL_VALID(EVAL_VALID), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pts(input int n, input logic [3:0] px, input logic [3:0] py);
        for (int i = 0; i < n; i++) begin
            PT_VALID = 1'b1;
            X = px;
            Y = py;
            @(negedge CLK);
        end
        PT_VALID = 1'b0;
    endtask

    task automatic fire(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        DONE_IN = 1'b1;
        C1X = a;
        C1Y = b;
        C2X = c;
        C2Y = d;
        @(negedge CLK);
        DONE_IN = 1'b0;
    endtask

    task automatic expect_report(input string tag, input int e1, input int e2, input int eb, input int et,
                                 input logic eerr, input int elat);
        int cyc;
        cyc = 0;
        while (!EVAL_VALID && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
        check({tag, ".lat"}, cyc, elat);
        check({tag, ".cnt1"}, CNT1, e1);
        check({tag, ".cnt2"}, CNT2, e2);
        check({tag, ".both"}, BOTH, eb);
        check({tag, ".total"}, TOTAL, et);
        check({tag, ".err"}, ERR, eerr);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("rst.counts", {CNT1, CNT2, BOTH, TOTAL}, 0);
        check("rst.flags", {EVAL_VALID, BUSY, ERR}, 0);
        RST = 1'b1;
        @(negedge CLK);

        pts(40, 5, 5);
        fire(5, 5, 12, 12);
        check("cover.busy", BUSY, 1);
        expect_report("cover", 40, 0, 0, 40, 1'b0, 41);

        pts(20, 9, 5);
        pts(20, 9, 6);
        fire(5, 5, 15, 15);
        expect_report("bound", 20, 0, 0, 20, 1'b0, 41);

        pts(40, 8, 8);
        fire(6, 6, 10, 10);
        expect_report("overlap", 40, 40, 40, 40, 1'b0, 41);

        pts(39, 5, 5);
        fire(5, 5, 6, 6);
        expect_report("short", 39, 39, 39, 39, 1'b1, 40);
        repeat (5) @(negedge CLK);
        check("hold.total", TOTAL, 39);
        check("hold.ev", EVAL_VALID, 0);
        check("hold.err_cleared", ERR, 0);

        pts(41, 0, 0);
        fire(0, 0, 15, 15);
        expect_report("overflow", 40, 0, 0, 40, 1'b1, 41);

        pts(39, 1, 1);
        PT_VALID = 1'b1;
        X = 4;
        Y = 4;
        fire(0, 0, 4, 4);
        PT_VALID = 1'b0;
        expect_report("same_cycle", 39, 1, 0, 40, 1'b0, 41);

        pts(40, 3, 3);
        fire(3, 3, 0, 0);
        repeat (5) @(negedge CLK);
        check("midrst.busy_before", BUSY, 1);
        RST = 1'b0;
        #1;
        check("midrst.counts", {CNT1, CNT2, BOTH, TOTAL}, 0);
        check("midrst.flags", {EVAL_VALID, BUSY, ERR}, 0);
        @(negedge CLK);
        RST = 1'b1;
        evs = 0;
        repeat (60) begin
            @(negedge CLK);
            if (EVAL_VALID) evs++;
        end
        check("midrst.no_ev", evs, 0);

        pts(40, 3, 3);
        fire(3, 3, 3, 7);
        expect_report("b2b_a", 40, 40, 40, 40, 1'b0, 41);
        pts(40, 10, 10);
        fire(3, 3, 10, 12);
        expect_report("b2b_b", 0, 40, 0, 40, 1'b0, 41);

        pts(40, 2, 2);
        fire(2, 2, 15, 0);
        PT_VALID = 1'b1;
        X = 15;
        Y = 0;
        @(negedge CLK);
        DONE_IN = 1'b1;
        C1X = 15;
        C1Y = 0;
        C2X = 2;
        C2Y = 2;
        @(negedge CLK);
        DONE_IN = 1'b0;
        check("busyviol.busy", BUSY, 1);
        @(negedge CLK);
        PT_VALID = 1'b0;
        expect_report("busyviol", 40, 0, 0, 40, 1'b1, 38);

        fire(0, 0, 0, 0);
        check("empty.busy", BUSY, 1);
        check("empty.err", ERR, 1);
        expect_report("empty", 0, 0, 0, 0, 1'b1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
